ota_out_sampler: RTL and testbench

Digital back-end for the Digi-OTA comparator. It takes the OTA `Out` node, which is asynchronous and tri-stated whenever `EN` is low, and pulls it into the `clk` domain. A 3-tap majority vote deglitches the synchronised bit, and the block then measures a fixed window of qualified samples, reporting how many were 1 (duty/density) and how many times the value toggled. It sits directly downstream of the OTA; its result is read over a valid/ready handshake by the pin-mux/readout logic that drives `uo_out`.

---
 rtl/ota_sampler_pkg.sv | 20 ++
 rtl/ota_sync_vote.sv | 47 ++++
 rtl/ota_out_sampler.sv | 135 +++++++++++++
 tb/tb_ota_out_sampler.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ota_sampler_pkg.sv
// Shared types and constants for the OTA output sampler.
// Holds the sequencer state encoding and the front-end pipeline depths.
package ota_sampler_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    ACCUM = 2'd2,
    HOLD  = 2'd3
  } sampler_state_t;

  localparam int SYNC_STAGES = 2;
  localparam int VOTE_TAPS   = 3;
  localparam int ARM_CYCLES  = 3;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/ota_sync_vote.sv
// Front end: synchronises the OTA output and enable into the clock domain,
// deglitches the output with a 3-tap majority vote and keeps enable aligned.
module ota_sync_vote
  import ota_sampler_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic ota_out_i,
  input  logic ota_en_i,
  output logic f_o,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] out_sync_q;
  logic [SYNC_STAGES-1:0] en_sync_q;
  logic [VOTE_TAPS-2:0]   s_hist_q;
  logic                   s;
  logic                   q_s;
  logic                   f_d;
  logic                   f_q;
  logic                   q_q;

  assign s   = out_sync_q[SYNC_STAGES-1];
  assign q_s = en_sync_q[SYNC_STAGES-1];
  assign f_d = maj3(s, s_hist_q[0], s_hist_q[1]);

  // q is delayed one extra stage so it lines up with the registered vote
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_sync_q <= '0;
      en_sync_q  <= '0;
      s_hist_q   <= '0;
      f_q        <= 1'b0;
      q_q        <= 1'b0;
    end else begin
      out_sync_q <= {out_sync_q[SYNC_STAGES-2:0], ota_out_i};
      en_sync_q  <= {en_sync_q[SYNC_STAGES-2:0], ota_en_i};
      s_hist_q   <= {s_hist_q[VOTE_TAPS-3:0], s};
      f_q        <= f_d;
      q_q        <= q_s;
    end
  end

  assign f_o = f_q;
  assign q_o = q_q;

endmodule

// File: rtl/ota_out_sampler.sv
// Measures a window of qualified, deglitched OTA samples: number of ones and
// number of value changes, returned over a valid/ready handshake.
module ota_out_sampler #(
  parameter int WIN_LOG2 = 8,
  parameter int TOG_W    = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                ota_out_i,
  input  logic                ota_en_i,
  input  logic                start_i,
  input  logic                cont_i,
  input  logic                abort_i,
  output logic                busy_o,
  output logic                result_valid_o,
  input  logic                result_ready_i,
  output logic [WIN_LOG2:0]   ones_o,
  output logic [TOG_W-1:0]    toggles_o
);
  import ota_sampler_pkg::*;

  localparam logic [WIN_LOG2:0] LAST_IDX = {1'b0, {WIN_LOG2{1'b1}}};
  localparam logic [WIN_LOG2:0] CNT_ONE  = {{WIN_LOG2{1'b0}}, 1'b1};
  localparam logic [TOG_W-1:0]  TOG_ONE  = {{(TOG_W-1){1'b0}}, 1'b1};
  localparam logic [TOG_W-1:0]  TOG_MAX  = '1;
  localparam logic [1:0]        ARM_LAST = 2'(ARM_CYCLES - 1);

  sampler_state_t    state_q;
  logic [1:0]        arm_cnt_q;
  logic [WIN_LOG2:0] cnt_q;
  logic [WIN_LOG2:0] ones_q;
  logic [TOG_W-1:0]  tog_q;
  logic              prev_f_q;
  logic              cont_q;
  logic              busy_q;
  logic              valid_q;

  logic              f;
  logic              q;
  logic              toggle_d;
  logic              handshake_d;

  ota_sync_vote u_front (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .ota_out_i (ota_out_i),
    .ota_en_i  (ota_en_i),
    .f_o       (f),
    .q_o       (q)
  );

  // the first sample of a window has no predecessor, so it never toggles
  assign toggle_d    = (cnt_q != '0) && (f != prev_f_q) && (tog_q != TOG_MAX);
  assign handshake_d = valid_q && result_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      arm_cnt_q <= '0;
      cnt_q     <= '0;
      ones_q    <= '0;
      tog_q     <= '0;
      prev_f_q  <= 1'b0;
      cont_q    <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else if (abort_i) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q   <= ARM;
            busy_q    <= 1'b1;
            arm_cnt_q <= '0;
            cnt_q     <= '0;
            ones_q    <= '0;
            tog_q     <= '0;
            cont_q    <= cont_i;
          end
        end
        ARM: begin
          if (arm_cnt_q == ARM_LAST) begin
            state_q <= ACCUM;
          end else begin
            arm_cnt_q <= arm_cnt_q + 2'd1;
          end
        end
        ACCUM: begin
          if (q) begin
            cnt_q    <= cnt_q + CNT_ONE;
            ones_q   <= ones_q + {{WIN_LOG2{1'b0}}, f};
            prev_f_q <= f;
            if (toggle_d) begin
              tog_q <= tog_q + TOG_ONE;
            end
            if (cnt_q == LAST_IDX) begin
              state_q <= HOLD;
            end
          end
        end
        HOLD: begin
          // valid rises one cycle after the window closes and stays until taken
          if (handshake_d) begin
            valid_q <= 1'b0;
            if (cont_q) begin
              state_q <= ACCUM;
              cnt_q   <= '0;
              ones_q  <= '0;
              tog_q   <= '0;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            valid_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o         = busy_q;
  assign result_valid_o = valid_q;
  assign ones_o         = ones_q;
  assign toggles_o      = tog_q;

endmodule

// File: tb/tb_ota_out_sampler.sv
// Self-checking bench for ota_out_sampler (WIN_LOG2=4): directed scenarios
// plus randomized traffic against a behavioural window model.
module tb_ota_out_sampler;

  localparam int WL  = 4;
  localparam int WIN = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ota_out = 1'b0, ota_en = 1'b0, start = 1'b0, cont = 1'b0, abort = 1'b0, ready = 1'b0;
  logic busy, valid, busy3, valid3;
  logic [WL:0] ones, ones3;
  logic [7:0] tog;
  logic [2:0] tog3;

  always #5 clk = ~clk;

  ota_out_sampler #(.WIN_LOG2(WL), .TOG_W(8)) dut (
    .clk_i(clk), .rst_i(rst), .ota_out_i(ota_out), .ota_en_i(ota_en),
    .start_i(start), .cont_i(cont), .abort_i(abort), .busy_o(busy),
    .result_valid_o(valid), .result_ready_i(ready), .ones_o(ones), .toggles_o(tog));

  ota_out_sampler #(.WIN_LOG2(WL), .TOG_W(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .ota_out_i(ota_out), .ota_en_i(ota_en),
    .start_i(start), .cont_i(cont), .abort_i(abort), .busy_o(busy3),
    .result_valid_o(valid3), .result_ready_i(ready), .ones_o(ones3), .toggles_o(tog3));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the value seen by the window at edge k is the
  // majority of ota_out sampled at edges k-3..k-5, qualified by ota_en at k-3.
  int h_out[6];
  int h_en[6];
  int m_mode;   // 0 idle, 1 arming, 2 accumulating, 3 holding a result
  int m_arm, m_n, m_ones, m_tog, m_tog3, m_prevf, m_cont, m_valid;

  always @(posedge clk or posedge rst) begin
    int fv;
    if (rst) begin
      for (int i = 0; i < 6; i++) begin h_out[i] = 0; h_en[i] = 0; end
      m_mode = 0; m_arm = 0; m_n = 0; m_ones = 0; m_tog = 0; m_tog3 = 0;
      m_prevf = 0; m_cont = 0; m_valid = 0;
    end else begin
      for (int i = 5; i > 0; i--) begin h_out[i] = h_out[i-1]; h_en[i] = h_en[i-1]; end
      h_out[0] = int'(ota_out);
      h_en[0]  = int'(ota_en);
      fv = ((h_out[3] + h_out[4] + h_out[5]) >= 2) ? 1 : 0;
      if (abort) begin
        m_mode = 0; m_valid = 0;
      end else if (m_mode == 0) begin
        if (start) begin
          m_mode = 1; m_arm = 3; m_n = 0; m_ones = 0; m_tog = 0; m_tog3 = 0;
          m_cont = int'(cont);
        end
      end else if (m_mode == 1) begin
        m_arm--;
        if (m_arm == 0) m_mode = 2;
      end else if (m_mode == 2) begin
        if (h_en[3] == 1) begin
          if (m_n > 0 && fv != m_prevf) begin
            if (m_tog < 255) m_tog++;
            if (m_tog3 < 7) m_tog3++;
          end
          m_ones += fv;
          m_prevf = fv;
          m_n++;
          if (m_n == WIN) m_mode = 3;
        end
      end else begin
        if (m_valid == 1 && ready) begin
          m_valid = 0;
          if (m_cont == 1) begin
            m_mode = 2; m_n = 0; m_ones = 0; m_tog = 0; m_tog3 = 0;
          end else begin
            m_mode = 0;
          end
        end else begin
          m_valid = 1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #1;
      chk("busy", busy, (m_mode != 0) ? 1 : 0);
      chk("valid", valid, m_valid);
      chk("ones", ones, m_ones);
      chk("toggles", tog, m_tog);
      chk("toggles_sat3", tog3, m_tog3);
    end
  end

  // Stimulus: pattern generator advanced once per falling edge.
  int pk = 0;
  int pat_out = 4;
  int pat_en = 0;

  task automatic tick();
    @(negedge clk);
    pk++;
    start = 1'b0;
    abort = 1'b0;
    case (pat_out)
      0: ota_out = 1'b1;
      1: ota_out = pk[0];
      2: ota_out = ((pk % 5) == 0);
      3: ota_out = 1'($urandom_range(0, 1));
      default: ota_out = 1'b0;
    endcase
    case (pat_en)
      0: ota_en = 1'b1;
      1: ota_en = pk[0];
      default: ota_en = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  // Starts a window after letting the front end settle; lat counts edges
  // from the edge that accepts start to the edge that raises result_valid.
  task automatic measure(input int po, input int pe, input logic c, output int lat);
    pat_out = po;
    pat_en  = pe;
    repeat (8) tick();
    cont  = c;
    start = 1'b1;
    tick();
    lat = 0;
    while (!valid && lat < 200) begin
      tick();
      lat++;
    end
    chk("valid_timeout", (lat < 200) ? 1 : 0, 1);
  endtask

  task automatic take_result();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("idle_after_take", {busy, valid}, 0);
  endtask

  initial begin
    int lat, n;
    logic [WL:0] o_snap;
    logic [7:0]  t_snap;
    logic        saw_valid;

    rst = 1'b1;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_ones", ones, 0);
    chk("rst_toggles", tog, 0);
    rst = 1'b0;

    measure(0, 0, 1'b0, lat);
    chk("const_lat", lat, 20);
    chk("const_ones", ones, 16);
    chk("const_tog", tog, 0);
    take_result();

    measure(1, 0, 1'b0, lat);
    chk("alt_ones", ones, 8);
    chk("alt_tog", tog, 15);
    chk("alt_tog_sat3", tog3, 7);
    take_result();

    measure(2, 0, 1'b0, lat);
    chk("glitch_ones", ones, 0);
    chk("glitch_tog", tog, 0);
    take_result();

    measure(0, 1, 1'b0, lat);
    chk("half_lat", (lat >= 34 && lat <= 37) ? 1 : 0, 1);
    chk("half_ones", ones, 16);
    take_result();

    measure(3, 0, 1'b1, lat);
    chk("cont_lat", lat, 20);
    o_snap = ones;
    t_snap = tog;
    repeat (10) tick();
    chk("bp_ones_stable", ones, o_snap);
    chk("bp_tog_stable", tog, t_snap);
    chk("bp_valid_held", valid, 1);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("cont_busy_kept", busy, 1);
    n = 0;
    while (!valid && n < 200) begin
      tick();
      n++;
    end
    chk("cont_second_lat", n, 17);
    abort = 1'b1;
    tick();
    chk("cont_abort_idle", {busy, valid}, 0);

    pat_out = 0;
    pat_en  = 0;
    repeat (8) tick();
    start = 1'b1;
    tick();
    for (int i = 1; i <= 10; i++) tick();
    abort = 1'b1;
    tick();
    chk("abort_busy", busy, 0);
    chk("abort_ones_kept", ones, 7);
    saw_valid = 1'b0;
    repeat (25) begin
      tick();
      if (valid) saw_valid = 1'b1;
    end
    chk("abort_no_valid", saw_valid, 0);

    start = 1'b1;
    tick();
    repeat (8) tick();
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_ones", ones, 0);
    repeat (2) tick();
    rst = 1'b0;
    measure(0, 0, 1'b0, lat);
    chk("post_rst_lat", lat, 20);
    chk("post_rst_ones", ones, 16);
    take_result();

    pat_out = 3;
    pat_en  = 2;
    repeat (1500) begin
      tick();
      start = ($urandom_range(0, 9) == 0);
      cont  = 1'($urandom_range(0, 1));
      ready = 1'($urandom_range(0, 1));
      abort = ($urandom_range(0, 199) == 0);
    end
    ready = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
